// File: rtl/conv_pkg.sv
// Shared types, default geometry and the output post-processing function for the conv stage.
package conv_pkg;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int K_DEF     = 3;
  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 20;

  localparam int OW   = IMG_W_DEF - K_DEF + 1;
  localparam int OH   = IMG_H_DEF - K_DEF + 1;
  localparam int NPIX = OW * OH;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} conv_state_t;

  localparam logic signed [AW_DEF-1:0] SAT_MAX = AW_DEF'((2 ** DW_DEF) - 1);

  // ReLU, then arithmetic right shift, then clamp to the unsigned output range.
  function automatic logic [DW_DEF-1:0] relu_sat(input logic signed [AW_DEF-1:0] acc,
                                                 input int shift);
    logic signed [AW_DEF-1:0] v;
    v = acc >>> shift;
    if (acc < 0)
      relu_sat = '0;
    else if (v > SAT_MAX)
      relu_sat = '1;
    else
      relu_sat = v[DW_DEF-1:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: unsigned pixel times signed weight, one product per enabled cycle.
module conv_mac #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DW-1:0]        pix,
  input  logic signed [DW-1:0] wgt,
  output logic signed [AW-1:0] acc
);

  logic signed [DW:0]   pix_s;
  logic signed [2*DW:0] prod;

  // The pixel gets a zero sign bit so the product is a true signed x unsigned multiply.
  assign pix_s = $signed({1'b0, pix});
  assign prod  = pix_s * wgt;

  // Accumulator register; clear wins over enable so a new window always starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + AW'(prod);
  end

endmodule

// File: rtl/conv_top.sv
// Single-channel valid convolution with ReLU/shift/saturate; image, kernel and results in local memories.
module conv_top
  import conv_pkg::*;
#(
  parameter int    IMG_W    = IMG_W_DEF,
  parameter int    IMG_H    = IMG_H_DEF,
  parameter int    K        = K_DEF,
  parameter int    DW       = DW_DEF,
  parameter int    AW       = AW_DEF,
  parameter int    SHIFT    = 4,
  parameter string IMG_FILE = "image.mem",
  parameter string KER_FILE = "kernel.mem"
) (
  input  logic clk,
  input  logic start,
  input  logic reset,
  output logic done
);

  localparam int OWL = IMG_W - K + 1;
  localparam int OHL = IMG_H - K + 1;
  localparam int IAW = $clog2(IMG_W * IMG_H);
  localparam int KAW = $clog2(K * K + 1);
  localparam int OAW = $clog2(OWL * OHL);
  localparam int RW  = $clog2(OHL + 1);
  localparam int CW  = $clog2(OWL + 1);
  localparam int KW  = $clog2(K + 1);

  logic [DW-1:0] img_mem [IMG_W*IMG_H];
  logic [DW-1:0] ker_mem [K*K];
  logic [DW-1:0] out_mem [OWL*OHL];

  conv_state_t state, state_next;

  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [KW-1:0] kr, kc;

  logic                 mac_en, mac_clr;
  logic                 last_k, last_pix;
  logic [IAW-1:0]       img_addr;
  logic [KAW-1:0]       ker_addr;
  logic [OAW-1:0]       out_addr;
  logic [DW-1:0]        pix;
  logic signed [DW-1:0] wgt;
  logic signed [AW-1:0] acc;

  // Window addressing: the current kernel tap over the current output position.
  always_comb begin
    img_addr = IAW'((int'(r) + int'(kr)) * IMG_W + int'(c) + int'(kc));
    ker_addr = KAW'(int'(kr) * K + int'(kc));
    out_addr = OAW'(int'(r) * OWL + int'(c));
    pix      = img_mem[img_addr];
    wgt      = $signed(ker_mem[ker_addr]);
    last_k   = (kr == KW'(K - 1)) && (kc == KW'(K - 1));
    last_pix = (r == RW'(OHL - 1)) && (c == CW'(OWL - 1));
  end

  conv_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .pix   (pix),
    .wgt   (wgt),
    .acc   (acc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state and MAC control; the accumulator is cleared whenever no window is being summed.
  always_comb begin
    state_next = state;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    case (state)
      IDLE: begin
        mac_clr = 1'b1;
        if (start)
          state_next = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_k)
          state_next = WRITE;
      end
      WRITE: begin
        mac_clr = 1'b1;
        state_next = last_pix ? DONE : MAC;
      end
      DONE: begin
        if (!start)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Kernel tap counters (kc fastest) and output position counters (c fastest).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r  <= '0;
      c  <= '0;
      kr <= '0;
      kc <= '0;
    end else begin
      case (state)
        IDLE: begin
          r  <= '0;
          c  <= '0;
          kr <= '0;
          kc <= '0;
        end
        MAC: begin
          if (kc == KW'(K - 1)) begin
            kc <= '0;
            kr <= (kr == KW'(K - 1)) ? '0 : kr + 1'b1;
          end else begin
            kc <= kc + 1'b1;
          end
        end
        WRITE: begin
          if (c == CW'(OWL - 1)) begin
            c <= '0;
            r <= (r == RW'(OHL - 1)) ? '0 : r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result store; deliberately not reset so a partial run stays visible after an abort.
  always_ff @(posedge clk) begin
    if (state == WRITE)
      out_mem[out_addr] <= relu_sat(acc, SHIFT);
  end

  // done is a registered copy of the DONE state, so it trails the state by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      done <= 1'b0;
    else
      done <= (state == DONE);
  end

endmodule

// File: tb/tb_conv_top.sv
// Self-checking bench for conv_top: memories loaded hierarchically, expected pixels queued from a model.
module tb_conv_top;
  import conv_pkg::*;

  localparam int IW        = 28;
  localparam int KK        = 3;
  localparam int SHIFT_TB  = 0;
  localparam int RUN_EDGES = NPIX * (KK * KK + 1) + 1;
  localparam int TIMEOUT   = 8000;

  logic clk;
  logic start;
  logic reset;
  logic done;

  int errors;
  int checks;

  int img_m [IW*IW];
  int ker_m [KK*KK];
  logic [7:0] exp_q [$];

  conv_top #(
    .SHIFT    (SHIFT_TB),
    .IMG_FILE (""),
    .KER_FILE ("")
  ) dut (
    .clk   (clk),
    .start (start),
    .reset (reset),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference convolution for one output pixel.
  function automatic logic [7:0] model_pixel(input int r, input int c);
    int s;
    s = 0;
    for (int kr = 0; kr < KK; kr++)
      for (int kc = 0; kc < KK; kc++)
        s += img_m[(r + kr) * IW + c + kc] * ker_m[kr * KK + kc];
    if (s < 0) return 8'd0;
    s = s >>> SHIFT_TB;
    if (s > 255) return 8'd255;
    return s[7:0];
  endfunction

  task automatic load_mems();
    for (int i = 0; i < IW * IW; i++) dut.img_mem[i] = 8'(img_m[i]);
    for (int i = 0; i < KK * KK; i++) dut.ker_mem[i] = 8'(ker_m[i]);
  endtask

  task automatic push_expected();
    exp_q.delete();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        exp_q.push_back(model_pixel(r, c));
  endtask

  // Starts a run, times done, then drains the scoreboard against out_mem.
  task automatic run_and_check(input string name, input bit keep_start);
    int cycles;
    logic [7:0] e;
    load_mems();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    cycles = 0;
    while (!done && cycles < TIMEOUT) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s timeout: done not seen after %0d cycles", name, cycles);
      return;
    end
    if (cycles !== RUN_EDGES) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, cycles, RUN_EDGES);
    end
    for (int i = 0; i < NPIX; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (dut.out_mem[i] !== e) begin
        errors++;
        $display("[TB] FAIL %s out_mem[%0d]: got %0d, expected %0d", name, i, dut.out_mem[i], e);
      end
    end
  endtask

  task automatic return_idle();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    #40;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b, expected 0", done);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("[TB] FAIL reset_state: got %0d, expected %0d", dut.state, IDLE);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < IW * IW; i++) img_m[i] = 1;
    for (int i = 0; i < KK * KK; i++) ker_m[i] = 1;
    run_and_check("all_ones", 1'b0);
    return_idle();
  endtask

  task automatic test_diag();
    for (int i = 0; i < IW; i++)
      for (int j = 0; j < IW; j++)
        img_m[i * IW + j] = i + j;
    for (int i = 0; i < KK * KK; i++) ker_m[i] = (i == 4) ? 1 : 0;
    run_and_check("diag", 1'b0);
    return_idle();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < IW * IW; i++) img_m[i] = 255;
    for (int i = 0; i < KK * KK; i++) ker_m[i] = 127;
    run_and_check("saturate", 1'b0);
    return_idle();
  endtask

  task automatic test_relu();
    for (int i = 0; i < IW * IW; i++) img_m[i] = 255;
    for (int i = 0; i < KK * KK; i++) ker_m[i] = -1;
    run_and_check("relu", 1'b0);
    return_idle();
  endtask

  // start stays high through the whole run and after it; DONE must hold without a rerun.
  task automatic test_back_to_back();
    for (int i = 0; i < IW; i++)
      for (int j = 0; j < IW; j++)
        img_m[i * IW + j] = (i * 7 + j * 3) % 256;
    for (int i = 0; i < KK * KK; i++) ker_m[i] = i - 4;
    run_and_check("hold_run1", 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_done: got %b, expected 1", done);
    end
    checks++;
    if (dut.state !== DONE) begin
      errors++;
      $display("[TB] FAIL hold_state: got %0d, expected %0d", dut.state, DONE);
    end
    return_idle();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_done: got %b, expected 0", done);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("[TB] FAIL release_state: got %0d, expected %0d", dut.state, IDLE);
    end
    run_and_check("hold_run2", 1'b0);
    return_idle();
  endtask

  task automatic test_midrun_reset();
    for (int i = 0; i < IW * IW; i++) img_m[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < KK * KK; i++) ker_m[i] = int'($urandom_range(0, 255)) - 128;
    load_mems();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_done: got %b, expected 0", done);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("[TB] FAIL abort_state: got %0d, expected %0d", dut.state, IDLE);
    end
    #20;
    @(negedge clk);
    reset = 1'b1;
    run_and_check("restart", 1'b0);
    return_idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    start  = 1'b0;
    reset  = 1'b0;
    test_reset();
    test_all_ones();
    test_diag();
    test_saturate();
    test_relu();
    test_back_to_back();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
